decoder_pipe: RTL
=================

// Module: decoder_pipe
// PURPOSE
//  Parametrised, pipelined address decoder. Converts an ADDR_W-bit index into a
//  NUM_OUT-wide one-hot or thermometer vector behind a valid/ready handshake with
//  a 2-entry skid buffer, so it can sit between decode and writeback in the
//  processor. Also flags out-of-range indices and keeps a saturating count of them.
// PARAMETERS
//  ADDR_W   5    index width in bits
//  NUM_OUT  32   output vector width; legal range 2 .. 2**ADDR_W
// PORTS
//  clock       in   1        single clock, rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  in_valid    in   1        producer has a request
//  in_ready    out  1        block can accept a request (registered)
//  in_addr     in   ADDR_W   index to decode
//  in_en       in   1        0 = emit an all-zero vector (still a transfer)
//  in_mode     in   1        0 = one-hot, 1 = thermometer
//  out_valid   out  1        out_vec/out_oor hold a result
//  out_ready   in   1        consumer accepts the result
//  out_vec     out  NUM_OUT  decoded vector
//  out_oor     out  1        result came from in_addr >= NUM_OUT
//  oor_cnt     out  8        saturating count of accepted out-of-range requests
// BEHAVIOUR
//  - Input transfer: in_valid && in_ready at a rising edge. Output transfer:
//    out_valid && out_ready at a rising edge.
//  - Decode rules, applied at input transfer:
//    - in_addr >= NUM_OUT: out_vec = 0, out_oor = 1, whatever in_en/in_mode.
//    - Otherwise, with in_en = 1:
//      - mode 0: out_vec[i] = (i == in_addr).
//      - mode 1: out_vec[i] = (i <= in_addr).
//    - Otherwise, with in_en = 0: out_vec = 0, out_oor = 0.
//  - Latency: a request accepted at edge k is on out_* after edge k (1 cycle).
//    Throughput is 1 per cycle while out_ready = 1.
//  - Storage: main register (drives outputs) + skid register. States by occupancy:
//    - EMPTY: in_ready = 1, out_valid = 0.
//      - Input transfer -> ONE.
//    - ONE: in_ready = 1, out_valid = 1.
//      - Input and output transfer together -> ONE (new data into main).
//      - Input transfer only -> TWO (data into skid).
//      - Output transfer only -> EMPTY.
//    - TWO: in_ready = 0, out_valid = 1.
//      - Output transfer -> ONE (skid moves to main).
//  - Ordering is FIFO. No request is dropped or duplicated.
//  - out_vec/out_oor stay stable while out_valid = 1 and out_ready = 0.
//  - in_ready depends only on state, never combinationally on out_ready.
//  - oor_cnt increments by 1 on each input transfer with in_addr >= NUM_OUT.
//    It holds at 255 and clears only on reset.
//  - Reset (asserted at any time, including mid-transfer):
//    - Immediately: out_valid = 0, out_vec = 0, out_oor = 0, oor_cnt = 0,
//      in_ready = 1, state EMPTY.
//    - Buffered requests are discarded.
//    - The first edge after deassertion may already accept a request.
// CONFIGURATION
//  DEC_ZERO_MASK_EN defined:
//   - out_vec[0] is forced to 0 in both modes (register-0 write suppression).
//   - in_addr = 0 in mode 0 gives out_vec = 0 with out_oor = 0.
//  DEC_ZERO_MASK_EN undefined: bit 0 decodes like every other bit.
// TESTING (ADDR_W=5, NUM_OUT=32 unless noted)
//  1. Reset, then out_ready=1; send addr 0,1,31 mode 0 en 1 on consecutive cycles
//     -> out_vec = 0x1, 0x2, 0x8000_0000 on the following 3 cycles, in_ready stays 1.
//  2. Mode 1, addr 4, en 1 -> out_vec = 0x1F. Same request with en 0 -> out_vec = 0.
//  3. NUM_OUT=20: send addr 25 -> out_vec = 0, out_oor = 1, oor_cnt = 1.
//     Send 300 such requests -> oor_cnt = 255.
//  4. out_ready=0; send addr 3, then 7 -> in_ready = 0 after 2nd accept, out_vec = 0x8
//     held stable. Raise out_ready -> 0x8 then 0x80 delivered, in_ready back to 1.
//  5. Assert reset_n=0 mid-cycle while in state TWO -> out_valid, oor_cnt, out_vec = 0
//     at once; after release, the next request is the first one output.
//  6. With DEC_ZERO_MASK_EN defined: addr 0 mode 0 -> 0x0. Addr 2 mode 1 -> 0x6.

Source files
------------

// File: rtl/decoder_pipe.sv
// Pipelined index decoder (one-hot / thermometer) behind valid/ready with a 2-entry skid buffer.
// Optional macro DEC_ZERO_MASK_EN forces out_vec[0] to 0 in both modes.
module decoder_pipe #(
    parameter int ADDR_W  = 5,
    parameter int NUM_OUT = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic               in_en,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_vec,
    output logic               out_oor,
    output logic [7:0]         oor_cnt
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    localparam logic [ADDR_W:0] NUM_OUT_W = (ADDR_W+1)'(NUM_OUT);

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [NUM_OUT-1:0]   main_vec_q, skid_vec_q;
    logic                 main_oor_q, skid_oor_q;
    logic [7:0]           cnt_q;
    logic                 load_main, load_skid, main_from_skid;
    logic                 in_fire, out_fire;
    logic                 dec_oor;
    logic [NUM_OUT-1:0]   dec_raw, dec_vec;

    assign dec_oor = {1'b0, in_addr} >= NUM_OUT_W;

    // An out-of-range or disabled request gates every bit to zero.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dec
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            assign dec_raw[gi] = !dec_oor && in_en &&
                                 (in_mode ? (IDX <= in_addr) : (IDX == in_addr));
        end
    endgenerate

`ifdef DEC_ZERO_MASK_EN
    assign dec_vec = dec_raw & ~NUM_OUT'(1);
`else
    assign dec_vec = dec_raw;
`endif

    assign in_fire   = in_valid && in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d   = S_ONE;
                    load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_d   = S_TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d   = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    state_d        = S_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_vec_q <= '0;
            main_oor_q <= 1'b0;
            skid_vec_q <= '0;
            skid_oor_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            if (load_main) begin
                main_vec_q <= main_from_skid ? skid_vec_q : dec_vec;
                main_oor_q <= main_from_skid ? skid_oor_q : dec_oor;
            end
            if (load_skid) begin
                skid_vec_q <= dec_vec;
                skid_oor_q <= dec_oor;
            end
            if (in_fire && dec_oor && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign in_ready = in_ready_q;
    assign out_vec  = main_vec_q;
    assign out_oor  = main_oor_q;
    assign oor_cnt  = cnt_q;
endmodule
